// File: rtl/systolic_pkg.sv
// systolic_pkg: shared collector state, output-beat marker and 2x2 result type
package systolic_pkg;
  typedef enum logic [1:0] {WAIT_B1, WAIT_B2, DRAIN_OE} col_state_t;
  localparam logic [7:0] OE_BEAT = 8'hFF;
  typedef struct packed {
    logic [7:0] c00;
    logic [7:0] c01;
    logic [7:0] c10;
    logic [7:0] c11;
  } c_mat_t;
  function automatic logic [15:0] decode_row(input logic [7:0] uo, input logic [7:0] uio);
    return {uio[7:4], uo[7:4], uio[3:0], uo[3:0]};
  endfunction
endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous c_mat_t FIFO (clk, rst, push/din, pop, full/empty) with a registered head
module result_fifo
  import systolic_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  c_mat_t din,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output c_mat_t head
);
  localparam int AW = $clog2(DEPTH);
  c_mat_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0] cnt, cnt_left;
  logic do_pop, do_push;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_nxt = rd_ptr + AW'(do_pop);
  assign cnt_left = cnt - (AW+1)'(do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      head <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_nxt;
      cnt <= cnt_left + (AW+1)'(do_push);
      if (cnt_left != '0) head <= mem[rd_nxt];
      else if (do_push) head <= din;
    end
  end
endmodule

// File: rtl/systolic_result_collector.sv
// systolic_result_collector: reassembles two-beat nibble-split core output into 2x2 results, buffers them and hands them out over valid/ready
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            mm_uo,
  input  logic [7:0]            mm_uio,
  input  logic [7:0]            mm_oe,
  output logic [7:0]            res_c00,
  output logic [7:0]            res_c01,
  output logic [7:0]            res_c10,
  output logic [7:0]            res_c11,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  proto_err,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  col_state_t state;
  logic [15:0] row0, row_now;
  logic beat, push, pop, full, empty;
  c_mat_t din, head;
  assign beat = mm_oe == OE_BEAT;
  assign row_now = decode_row(mm_uo, mm_uio);
  assign push = state == WAIT_B2 && beat;
  assign pop = res_valid && res_ready;
  assign din = {row0, row_now};
  assign res_valid = !empty;
  assign res_c00 = head.c00;
  assign res_c01 = head.c01;
  assign res_c10 = head.c10;
  assign res_c11 = head.c11;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_B1;
      row0 <= '0;
      proto_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      case (state)
        WAIT_B1: begin
          if (beat) row0 <= row_now;
          state <= beat ? WAIT_B2 : WAIT_B1;
        end
        WAIT_B2: begin
          if (!beat) proto_err <= 1'b1;
          state <= beat ? DRAIN_OE : WAIT_B1;
        end
        DRAIN_OE: begin
          if (beat) proto_err <= 1'b1;
          state <= beat ? DRAIN_OE : WAIT_B1;
        end
        default: state <= WAIT_B1;
      endcase
      if (push && full && !pop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
  result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (din),
    .pop  (pop),
    .full (full),
    .empty(empty),
    .head (head)
  );
endmodule

// File: tb/tb_systolic_result_collector.sv
// tb_systolic_result_collector: directed stimulus checked every cycle against a queue-based behavioural model
module tb_systolic_result_collector;
  import systolic_pkg::*;
  localparam int DEPTH = 2;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] mm_uo = '0, mm_uio = '0, mm_oe = '0;
  logic res_ready = 1'b0;
  logic [7:0] res_c00, res_c01, res_c10, res_c11;
  logic res_valid, proto_err;
  logic [DW-1:0] drop_cnt;
  int checks = 0;
  int errors = 0;
  c_mat_t q[$];
  c_mat_t hd = '0;
  int run = 0;
  logic [7:0] r0a = '0, r0b = '0;
  bit perr = 1'b0;
  int drops = 0;

  always #5 clk = ~clk;

  systolic_result_collector #(.FIFO_DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .mm_uo    (mm_uo),
    .mm_uio   (mm_uio),
    .mm_oe    (mm_oe),
    .res_c00  (res_c00),
    .res_c01  (res_c01),
    .res_c10  (res_c10),
    .res_c11  (res_c11),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .proto_err(proto_err),
    .drop_cnt (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_apply(input bit r, input logic [7:0] oe, input logic [7:0] uo, input logic [7:0] uio, input bit rdy);
    bit do_pop, do_push;
    c_mat_t nv;
    nv = '0;
    if (r) begin
      run = 0;
      q.delete();
      perr = 1'b0;
      drops = 0;
      hd = '0;
      r0a = '0;
      r0b = '0;
      return;
    end
    do_pop = q.size() > 0 && rdy;
    do_push = 1'b0;
    if (oe == 8'hFF) begin
      run++;
      if (run == 1) begin
        r0a = {uio[7:4], uo[7:4]};
        r0b = {uio[3:0], uo[3:0]};
      end else if (run == 2) begin
        do_push = 1'b1;
        nv = {r0a, r0b, uio[7:4], uo[7:4], uio[3:0], uo[3:0]};
      end else perr = 1'b1;
    end else begin
      if (run == 1) perr = 1'b1;
      run = 0;
    end
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      if (q.size() < DEPTH) q.push_back(nv);
      else if (drops < 255) drops++;
    end
    if (q.size() > 0) hd = q[0];
  endtask

  task automatic compare();
    chk("res_valid", 32'(res_valid), 32'(q.size() > 0));
    chk("proto_err", 32'(proto_err), 32'(perr));
    chk("drop_cnt", 32'(drop_cnt), 32'(drops));
    if (q.size() > 0) chk("head", {res_c00, res_c01, res_c10, res_c11}, hd);
  endtask

  task automatic cyc(input bit r, input logic [7:0] oe, input logic [7:0] uo, input logic [7:0] uio, input bit rdy);
    rst = r;
    mm_oe = oe;
    mm_uo = uo;
    mm_uio = uio;
    res_ready = rdy;
    @(posedge clk);
    model_apply(r, oe, uo, uio, rdy);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cyc(1'b0, 8'h00, 8'h00, 8'h00, rdy);
  endtask

  task automatic burst(input logic [7:0] uo1, input logic [7:0] uio1, input logic [7:0] uo2, input logic [7:0] uio2, input bit rdy);
    cyc(1'b0, 8'hFF, uo1, uio1, rdy);
    cyc(1'b0, 8'hFF, uo2, uio2, rdy);
  endtask

  task automatic do_reset();
    cyc(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    idle(1, 1'b0);
  endtask

  initial begin
    cyc(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_c00", 32'(res_c00), 32'd0);
    chk("rst_c11", 32'(res_c11), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    idle(1, 1'b1);

    burst(8'h36, 8'h11, 8'hB2, 8'h23, 1'b1);
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_c00", 32'(res_c00), 32'd19);
    chk("single_c01", 32'(res_c01), 32'd22);
    chk("single_c10", 32'(res_c10), 32'd43);
    chk("single_c11", 32'(res_c11), 32'd50);
    idle(1, 1'b1);
    chk("single_one_cycle", 32'(res_valid), 32'd0);

    burst(8'h36, 8'h11, 8'hB2, 8'h23, 1'b0);
    idle(2, 1'b0);
    burst(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    idle(2, 1'b0);
    burst(8'hAB, 8'hCD, 8'hEF, 8'h01, 1'b0);
    idle(2, 1'b0);
    chk("bp_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("bp_head0", {res_c00, res_c01, res_c10, res_c11}, 32'h13162B32);
    idle(1, 1'b1);
    chk("bp_head1", {res_c00, res_c01, res_c10, res_c11}, 32'h31427586);
    idle(1, 1'b1);
    chk("bp_drained", 32'(res_valid), 32'd0);

    burst(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    idle(2, 1'b0);
    burst(8'h05, 8'h06, 8'h07, 8'h08, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 8'hFF, 8'h09, 8'h0A, 1'b0);
    cyc(1'b0, 8'hFF, 8'h0B, 8'h0C, 1'b1);
    chk("full_pushpop_drop", 32'(drop_cnt), 32'd1);
    idle(3, 1'b1);

    do_reset();
    burst(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    idle(1, 1'b0);
    burst(8'h55, 8'h66, 8'h77, 8'h88, 1'b0);
    idle(1, 1'b0);
    for (int i = 0; i < 260; i++) begin
      burst(8'(i), 8'(i * 3), 8'(i * 5), 8'(i * 7), 1'b0);
      idle(1, 1'b0);
    end
    chk("drop_saturated", 32'(drop_cnt), 32'd255);
    idle(3, 1'b1);

    do_reset();
    cyc(1'b0, 8'hFF, 8'h36, 8'h11, 1'b1);
    idle(1, 1'b1);
    chk("trunc_proto_err", 32'(proto_err), 32'd1);
    chk("trunc_no_push", 32'(res_valid), 32'd0);
    burst(8'h9C, 8'h5A, 8'h3E, 8'hF1, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b1);

    do_reset();
    cyc(1'b0, 8'hFF, 8'h36, 8'h11, 1'b0);
    cyc(1'b0, 8'hFF, 8'hB2, 8'h23, 1'b0);
    cyc(1'b0, 8'hFF, 8'hDE, 8'hAD, 1'b0);
    cyc(1'b0, 8'hFF, 8'hBE, 8'hEF, 1'b0);
    idle(1, 1'b0);
    chk("long_proto_err", 32'(proto_err), 32'd1);
    chk("long_one_result", {res_c00, res_c01, res_c10, res_c11}, 32'h13162B32);
    idle(1, 1'b1);
    chk("long_only_one", 32'(res_valid), 32'd0);
    burst(8'h12, 8'h34, 8'h56, 8'h78, 1'b1);
    idle(2, 1'b1);

    do_reset();
    cyc(1'b0, 8'h0F, 8'hAA, 8'h55, 1'b1);
    cyc(1'b0, 8'hF0, 8'h12, 8'h34, 1'b1);
    cyc(1'b0, 8'h7F, 8'h56, 8'h78, 1'b1);
    chk("partial_no_err", 32'(proto_err), 32'd0);
    burst(8'h36, 8'h11, 8'hB2, 8'h23, 1'b0);
    chk("partial_then_good", {res_c00, res_c01, res_c10, res_c11}, 32'h13162B32);
    idle(2, 1'b1);

    do_reset();
    cyc(1'b0, 8'hFF, 8'h36, 8'h11, 1'b0);
    cyc(1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("midrst_valid", 32'(res_valid), 32'd0);
    chk("midrst_proto_err", 32'(proto_err), 32'd0);
    cyc(1'b0, 8'hFF, 8'hB2, 8'h23, 1'b0);
    idle(1, 1'b0);
    chk("midrst_no_result", 32'(res_valid), 32'd0);
    burst(8'h36, 8'h11, 8'hB2, 8'h23, 1'b0);
    cyc(1'b0, 8'hFF, 8'h00, 8'h00, 1'b0);
    cyc(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0);
    chk("drainrst_flush", 32'(res_valid), 32'd0);
    idle(2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
